// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared-memory signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
`timescale 1ns/1ps
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic [31:0] mem_data_out;
    logic        busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_data_out,
        output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
        output mem_address, mem_data_in, mem_we, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_data_out,
        input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_address, mem_data_in, mem_we, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-wide memory between a fetch port and a
// load/store port; sub-word stores are done as a read-modify-write pair.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int MEM_WORDS = 1024
) (
    input  logic          clk,
    input  logic          resetn,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} state_t;

    state_t      r_state;
    logic        r_port;       // 1 = data port owns the current access
    logic        r_last;       // 1 = data port was granted last
    logic        r_inr;
    logic [3:0]  r_be;
    logic [31:0] r_old;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_data_in;
    logic        r_mem_we;
    logic        r_i_rvalid, r_i_err, r_d_rvalid, r_d_err;
    logic [31:0] r_i_rdata, r_d_rdata;

    logic        w_gnt_i, w_gnt_d, w_we, w_inr, w_partial;
    logic [29:0] w_word;
    logic [31:0] w_cap;
    logic [31:0] w_merged;
    logic        w_unused;

    always_comb begin
        w_gnt_d   = resetn && (r_state == IDLE) && bus.d_req && (!bus.i_req || !r_last);
        w_gnt_i   = resetn && (r_state == IDLE) && bus.i_req && !w_gnt_d;
        w_word    = w_gnt_d ? bus.d_addr[31:2] : bus.i_addr[31:2];
        w_we      = w_gnt_d && bus.d_we;
        w_partial = w_we && (bus.d_be != 4'b0000) && (bus.d_be != 4'b1111);
        w_inr     = ({2'b00, w_word} < 32'(MEM_WORDS));
        w_cap     = r_inr ? bus.mem_data_out : 32'h0;
    end

    // Lanes selected by the latched byte enables come from the store data.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign w_merged[8*gi +: 8] = r_be[gi] ? r_mem_data_in[8*gi +: 8] : w_cap[8*gi +: 8];
        end
    endgenerate

    assign w_unused = &{1'b0, bus.i_addr[1:0], bus.d_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_port        <= 1'b0;
            r_last        <= 1'b0;
            r_inr         <= 1'b0;
            r_be          <= 4'h0;
            r_old         <= 32'h0;
            r_mem_address <= 32'h0;
            r_mem_data_in <= 32'h0;
            r_mem_we      <= 1'b0;
            r_i_rvalid    <= 1'b0;
            r_i_err       <= 1'b0;
            r_i_rdata     <= 32'h0;
            r_d_rvalid    <= 1'b0;
            r_d_err       <= 1'b0;
            r_d_rdata     <= 32'h0;
        end else begin
            r_mem_we   <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_i || w_gnt_d) begin
                        r_port        <= w_gnt_d;
                        r_last        <= w_gnt_d;
                        r_inr         <= w_inr;
                        r_be          <= bus.d_be;
                        r_mem_address <= {w_word, 2'b00};
                        r_mem_data_in <= bus.d_wdata;
                        if (w_partial) begin
                            r_state <= RMW_RD;
                        end else begin
                            r_state  <= ACCESS;
                            r_mem_we <= w_we && (bus.d_be == 4'b1111) && w_inr;
                        end
                    end
                end
                ACCESS: begin
                    r_state <= RESP;
                    if (r_port) begin
                        r_d_rvalid <= 1'b1;
                        r_d_rdata  <= w_cap;
                        r_d_err    <= !r_inr;
                    end else begin
                        r_i_rvalid <= 1'b1;
                        r_i_rdata  <= w_cap;
                        r_i_err    <= !r_inr;
                    end
                end
                RMW_RD: begin
                    r_state       <= RMW_WR;
                    r_old         <= w_cap;
                    r_mem_data_in <= w_merged;
                    r_mem_we      <= r_inr;
                end
                RMW_WR: begin
                    r_state    <= RESP;
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= r_old;
                    r_d_err    <= !r_inr;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.i_gnt       = w_gnt_i;
    assign bus.d_gnt       = w_gnt_d;
    assign bus.i_rvalid    = r_i_rvalid;
    assign bus.i_rdata     = r_i_rdata;
    assign bus.i_err       = r_i_err;
    assign bus.d_rvalid    = r_d_rvalid;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.d_err       = r_d_err;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_data_in = r_mem_data_in;
    assign bus.mem_we      = r_mem_we;
    assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requests push expected responses into per-port
// queues, a negedge monitor pops and compares them as rvalid pulses appear.
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic resetn;
    mem_arbiter_if bus ();

    mem_arbiter #(.MEM_WORDS(1024)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk_data;
        int          due;
    } exp_t;

    exp_t        exp_i[$];
    exp_t        exp_d[$];
    exp_t        e_i, e_d;
    int          we_cyc[$];
    logic [31:0] we_addr[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          gd0, gd1, gi0, gi1, gx;
    logic [31:0] mem [1024];

    // Memory model: combinational read, write at the clock edge.
    assign bus.mem_data_out = (bus.mem_address[31:12] == 20'h0) ? mem[bus.mem_address[11:2]] : 32'hDEADBEEF;
    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_address[31:12] == 20'h0)
            mem[bus.mem_address[11:2]] <= bus.mem_data_in;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int k);
        return 32'h1000_0000 + 32'(k) * 32'h0101;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.i_rvalid) begin
            if (exp_i.size() == 0) begin
                checks++; errors++;
                $display("FAIL i_unexpected_rvalid actual=rvalid at cycle %0d required=none", cyc);
            end else begin
                e_i = exp_i.pop_front();
                if (e_i.chk_data) check("i_rdata", bus.i_rdata, e_i.rdata);
                check("i_err", {31'b0, bus.i_err}, {31'b0, e_i.err});
                check("i_latency", cyc, e_i.due);
                $display("resp i rdata=%h err=%0d cycle=%0d", bus.i_rdata, bus.i_err, cyc);
            end
        end
        if (bus.d_rvalid) begin
            if (exp_d.size() == 0) begin
                checks++; errors++;
                $display("FAIL d_unexpected_rvalid actual=rvalid at cycle %0d required=none", cyc);
            end else begin
                e_d = exp_d.pop_front();
                if (e_d.chk_data) check("d_rdata", bus.d_rdata, e_d.rdata);
                check("d_err", {31'b0, bus.d_err}, {31'b0, e_d.err});
                check("d_latency", cyc, e_d.due);
                $display("resp d rdata=%h err=%0d cycle=%0d", bus.d_rdata, bus.d_err, cyc);
            end
        end
        if (bus.i_gnt || bus.d_gnt)
            check("gnt_exclusive", {31'b0, bus.i_gnt & bus.d_gnt}, 32'h0);
        if (bus.mem_we) begin
            we_cyc.push_back(cyc);
            we_addr.push_back(bus.mem_address);
            check("we_in_range", {31'b0, bus.mem_address[31:12] == 20'h0}, 32'h1);
        end
    end

    task automatic access(input bit port, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input bit chk_data,
                          input int lat, input bit push, output int gcyc);
        exp_t e;
        int   k;
        bit   got;
        @(posedge clk); #1;
        if (port) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        got = 1'b0; k = 0; gcyc = -1;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (port ? bus.d_gnt : bus.i_gnt) begin
                got = 1'b1; gcyc = cyc;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_gnt_timeout actual=no grant required=grant addr=%h", port ? "d" : "i", addr);
        end else begin
            $display("req %s we=%0d be=%b addr=%h wdata=%h granted cycle=%0d", port ? "d" : "i", we, be, addr, wdata, gcyc);
            if (push) begin
                e.rdata = exp_rdata; e.err = exp_err; e.chk_data = chk_data; e.due = gcyc + lat;
                if (port) exp_d.push_back(e); else exp_i.push_back(e);
            end
        end
        @(posedge clk); #1;
        if (port) bus.d_req = 1'b0; else bus.i_req = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] <= init_val(k);
        mem[2] <= 32'h0050_0093;
        mem[4] <= 32'h1122_3344;
        resetn = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;

        // Reset state, with requests asserted to show no grant leaks out.
        settle(3);
        check("rst_i_gnt", {31'b0, bus.i_gnt}, 32'h0);
        check("rst_d_gnt", {31'b0, bus.d_gnt}, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        check("rst_i_rdata", bus.i_rdata, 32'h0);
        check("rst_d_rdata", bus.d_rdata, 32'h0);
        check("rst_mem_address", bus.mem_address, 32'h0);
        check("rst_mem_data_in", bus.mem_data_in, 32'h0);
        check("rst_rvalid_err", {28'b0, bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err}, 32'h0);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;

        // Ties from reset: data first, then strict alternation.
        fork
            begin
                access(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, init_val(8), 1'b0, 1'b1, 2, 1'b1, gd0);
                access(1'b1, 1'b0, 4'h0, 32'h24, 32'h0, init_val(9), 1'b0, 1'b1, 2, 1'b1, gd1);
            end
            begin
                access(1'b0, 1'b0, 4'h0, 32'h00, 32'h0, init_val(0), 1'b0, 1'b1, 2, 1'b1, gi0);
                access(1'b0, 1'b0, 4'h0, 32'h04, 32'h0, init_val(1), 1'b0, 1'b1, 2, 1'b1, gi1);
            end
        join
        check("tie_i_after_d", gi0 - gd0, 3);
        check("tie_d_second", gd1 - gd0, 6);
        check("tie_i_second", gi1 - gd0, 9);
        settle(4);

        // Fetch of a known instruction word.
        access(1'b0, 1'b0, 4'h0, 32'h08, 32'h0, 32'h0050_0093, 1'b0, 1'b1, 2, 1'b1, gx);
        settle(3);

        // Full-word store then load back; fetch data must hold meanwhile.
        we_cyc.delete(); we_addr.delete();
        access(1'b1, 1'b1, 4'hF, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 2, 1'b1, gx);
        settle(3);
        check("full_we_count", we_cyc.size(), 1);
        if (we_cyc.size() == 1) check("full_we_cycle", we_cyc[0], gx + 1);
        access(1'b1, 1'b0, 4'h0, 32'h33, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, 2, 1'b1, gx);
        settle(3);
        check("i_rdata_hold", bus.i_rdata, 32'h0050_0093);

        // Partial store: one write cycle at N+2, response at N+3.
        we_cyc.delete(); we_addr.delete();
        access(1'b1, 1'b1, 4'b0010, 32'h10, 32'h0000_AB00, 32'h0, 1'b0, 1'b0, 3, 1'b1, gx);
        settle(4);
        check("rmw_we_count", we_cyc.size(), 1);
        if (we_cyc.size() == 1) begin
            check("rmw_we_cycle", we_cyc[0], gx + 2);
            check("rmw_we_addr", we_addr[0], 32'h10);
        end
        check("rmw_mem4", mem[4], 32'h1122_AB44);

        // Store with no byte enables is a no-op.
        we_cyc.delete(); we_addr.delete();
        access(1'b1, 1'b1, 4'b0000, 32'h14, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 2, 1'b1, gx);
        settle(3);
        check("be0_we_count", we_cyc.size(), 0);
        check("be0_mem5", mem[5], init_val(5));

        // Out-of-range accesses on both ports and every store flavour.
        we_cyc.delete(); we_addr.delete();
        access(1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1'b1, 2, 1'b1, gx);
        access(1'b0, 1'b0, 4'h0, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b1, 1'b1, 2, 1'b1, gx);
        access(1'b1, 1'b1, 4'b0001, 32'h0000_2000, 32'h55, 32'h0, 1'b1, 1'b1, 3, 1'b1, gx);
        access(1'b1, 1'b1, 4'hF, 32'h0000_1004, 32'h66, 32'h0, 1'b1, 1'b1, 2, 1'b1, gx);
        settle(4);
        check("oor_we_count", we_cyc.size(), 0);

        // Reset while in the read-modify-write write cycle.
        access(1'b1, 1'b1, 4'b1000, 32'h18, 32'h7700_0000, 32'h0, 1'b0, 1'b0, 3, 1'b0, gx);
        @(posedge clk); #2;
        check("abort_busy_before", {31'b0, bus.busy}, 32'h1);
        check("abort_we_before", {31'b0, bus.mem_we}, 32'h1);
        resetn = 1'b0;
        #1;
        check("abort_we_dropped", {31'b0, bus.mem_we}, 32'h0);
        check("abort_busy_dropped", {31'b0, bus.busy}, 32'h0);
        settle(3);
        check("abort_mem6", mem[6], init_val(6));
        @(posedge clk); #1;
        resetn = 1'b1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 32'h18;
        @(negedge clk);
        check("post_rst_gnt", {31'b0, bus.d_gnt}, 32'h1);
        if (bus.d_gnt) begin
            e_d.rdata = init_val(6); e_d.err = 1'b0; e_d.chk_data = 1'b1; e_d.due = cyc + 2;
            exp_d.push_back(e_d);
            $display("req d load addr=%h granted cycle=%0d after reset", bus.d_addr, cyc);
        end
        @(posedge clk); #1 bus.d_req = 1'b0;
        settle(6);

        check("drain_i", exp_i.size(), 0);
        check("drain_d", exp_d.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 1024: number of 32-bit words backed by the shared memory; word index = addr[31:2].
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  1  instruction-fetch read request; held until i_gnt.
REQ-005 i_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 i_gnt  output  1  fetch request accepted this cycle.
REQ-007 i_rvalid  output  1  one-cycle pulse: i_rdata/i_err valid.
REQ-008 i_rdata  output  32  fetched word.
REQ-009 i_err  output  1  fetch address out of range; qualified by i_rvalid.
REQ-010 d_req  input  1  load/store request; held with stable fields until d_gnt.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_be  input  4  store byte enables; bit n selects byte lane [8n+7:8n].
REQ-013 d_addr  input  32  data byte address; bits [1:0] ignored.
REQ-014 d_wdata  input  32  store data, lane-aligned.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  one-cycle pulse: load data or store completion.
REQ-017 d_rdata  output  32  loaded word (full word, unmasked).
REQ-018 d_err  output  1  data address out of range; qualified by d_rvalid.
REQ-019 mem_address  output  32  address to memory; {word index, 2'b00}.
REQ-020 mem_data_in  output  32  write data to memory.
REQ-021 mem_we  output  1  memory write enable, driven from a flop.
REQ-022 mem_data_out  input  32  combinational read data from memory.
REQ-023 busy  output  1  high whenever state is not IDLE.

Function
REQ-024 States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
REQ-025 Grants issue only in IDLE, combinationally from requests; i_gnt and d_gnt never both high; no grant in any other state.
REQ-026 Arbitration when only one request is pending: grant it; when both: grant the port not granted last (round-robin); last-granted resets to instruction, so the first tie goes to data.
REQ-027 On grant the port, address, we, be and wdata are latched; IDLE -> RMW_RD for a store with d_be neither 4'b0000 nor 4'b1111, otherwise IDLE -> ACCESS.
REQ-028 ACCESS: mem_address = latched address; mem_we = 1 only for an in-range store with be=4'b1111 (mem_data_in = wdata); read data captured from mem_data_out at the end of the cycle; -> RESP.
REQ-029 RMW_RD: mem_we = 0; captures the old word and merges wdata lanes per be; -> RMW_WR.
REQ-030 RMW_WR: mem_we = 1; mem_data_in = merged word; same mem_address; -> RESP.
REQ-031 RESP: pulse rvalid for the latched port with captured rdata and err; -> IDLE; a new grant is possible in the following cycle.
REQ-032 Latency, grant in cycle N: load, fetch or full-word store rvalid in N+2; partial store rvalid in N+3; sustained throughput one access per 3 cycles (4 for partial stores).
REQ-033 Out of range (addr[31:2] >= MEM_WORDS): no mem_we in any state; rdata = 0; err = 1 with rvalid; same latency as an in-range access.
REQ-034 Store with be=4'b0000 is handled as a no-op: follows the ACCESS path, mem_we stays 0, d_rvalid is issued at N+2, d_err = 0 when in range.
REQ-035 mem_address holds its value across every cycle in which mem_we is 1; mem_we is 0 in IDLE, ACCESS-read and RESP.
REQ-036 rdata and err outputs hold their last value until the next rvalid on the same port.
REQ-037 A request dropped before its grant has no effect; a request raised during busy waits until IDLE.

Reset
REQ-038 While resetn = 0: state IDLE, mem_we = 0, all gnt/rvalid/err = 0, busy = 0, i_rdata = d_rdata = 0, mem_address = 0, mem_data_in = 0, last-granted = instruction.
REQ-039 Reset asserted mid-operation aborts the access at once; mem_we drops asynchronously; no rvalid is issued for the aborted access.

Verification
REQ-040 Fetch: i_req=1, i_addr=0x8 with mem[2]=0x00500093 -> i_gnt at N; i_rvalid at N+2 with i_rdata=0x00500093 and i_err=0.
REQ-041 Tie: i_req and d_req (load) both high from reset -> d_gnt first; i_gnt at the next IDLE cycle; further ties alternate between ports.
REQ-042 Partial store: mem[4]=0x11223344, d_we=1, d_be=4'b0010, d_addr=0x10, d_wdata=0x0000AB00 -> mem_we high one cycle (N+2); mem[4]=0x1122AB44; d_rvalid at N+3.
REQ-043 Out of range: load d_addr=0x00001000 with MEM_WORDS=1024 -> d_rvalid at N+2 with d_err=1 and d_rdata=0; mem_we never high.
REQ-044 Reset during RMW_WR -> mem_we=0 immediately, mem[] unchanged; no d_rvalid; next grant is available the first cycle after resetn rises.
